// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: writable instruction memory with registered valid/ready fetch port, wait states and fault flagging
//   clk_i/rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o, req_addr_i   fetch request handshake and byte address
//   rsp_valid_o, rsp_data_o, rsp_fault_o  one-cycle response pulse, word (0 on fault), fault flag
//   load_en_i, load_addr_i, load_data_i   program-load write port (word index)
//   busy_o                 high while a fetch is waiting or being presented
//   INSTMEM_BOOT_ROM_EN    when defined, reset preloads words 0..4 with the boot program
module imem_fetch_unit #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_fault_o,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i,
  output logic                     busy_o
);
  localparam int AW = $clog2(DEPTH);
`ifdef INSTMEM_BOOT_ROM_EN
  localparam logic [31:0] BOOT [5] = '{32'h34080032, 32'hac080000, 32'h8c090000, 32'h01284820, 32'hac090004};
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_data_q, pend_data_d, data_q, data_d;
  logic        pend_fault_q, pend_fault_d, fault_q, fault_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] offset, fetch_word;
  logic        fault, accept;
  assign offset      = req_addr_i - BASE_ADDR;
  assign fault       = (req_addr_i[1:0] != 2'b00) || (req_addr_i < BASE_ADDR) || ({2'b00, offset[31:2]} >= 32'(DEPTH));
  assign fetch_word  = fault ? 32'h0 : mem_q[offset[AW+1:2]];
  assign req_ready_o = (state_q == S_IDLE || state_q == S_RESP) && !load_en_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = state_q == S_RESP;
  assign busy_o      = state_q != S_IDLE;
  assign rsp_data_o  = data_q;
  assign rsp_fault_o = fault_q;
  // The pending pair is captured at accept so later loads cannot alter it;
  // the visible outputs only change when the response is actually presented.
  always_comb begin
    state_d      = accept ? (WAIT_STATES == 0 ? S_RESP : S_WAIT)
                 : state_q == S_WAIT ? (cnt_q == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d        = accept ? 4'(WAIT_STATES) : state_q == S_WAIT ? cnt_q - 4'd1 : cnt_q;
    pend_data_d  = accept ? fetch_word : pend_data_q;
    pend_fault_d = accept ? fault : pend_fault_q;
    data_d       = state_d == S_RESP ? (accept ? fetch_word : pend_data_q) : data_q;
    fault_d      = state_d == S_RESP ? (accept ? fault : pend_fault_q) : fault_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_fault_q <= 1'b0;
      data_q       <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_data_q  <= pend_data_d;
      pend_fault_q <= pend_fault_d;
      data_q       <= data_d;
      fault_q      <= fault_d;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef INSTMEM_BOOT_ROM_EN
      for (int i = 0; i < 5; i++) mem_q[i] <= BOOT[i];
`endif
    end else if (load_en_i && 32'(load_addr_i) < 32'(DEPTH)) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: three configurations driven in lockstep and checked cycle by cycle against a timing/memory model
module tb_imem_fetch_unit;
  localparam int          DP [3] = '{256, 48, 256};
  localparam int          WS [3] = '{0, 3, 2};
  localparam logic [31:0] BA [3] = '{32'h0, 32'h100, 32'h0};
  localparam int          LM [3] = '{255, 63, 255};
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, load_en = 1'b0;
  logic [31:0] req_addr = '0, load_data = '0;
  logic [7:0]  load_addr = '0;
  logic [2:0]  rdy, vld, flt, bsy;
  logic [31:0] dat [3];
  logic [31:0] mm [3][256];
  logic [31:0] pd [3], ldat [3];
  logic        pf [3], lflt [3];
  int          rsp [3];
  int          c = 0, passed = 0, total = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    imem_fetch_unit #(.DEPTH(DP[g]), .WAIT_STATES(WS[g]), .BASE_ADDR(BA[g])) u (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy[g]), .req_addr_i(req_addr),
      .rsp_valid_o(vld[g]), .rsp_data_o(dat[g]), .rsp_fault_o(flt[g]), .load_en_i(load_en),
      .load_addr_i(load_addr[$clog2(DP[g])-1:0]), .load_data_i(load_data), .busy_o(bsy[g]));
  end
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[u%0d] cycle %0d: observed %h expected %h", tag, k, c, obs, exp);
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) mm[k][i] = '0;
`ifdef INSTMEM_BOOT_ROM_EN
      mm[k][0] = 32'h34080032; mm[k][1] = 32'hac080000; mm[k][2] = 32'h8c090000;
      mm[k][3] = 32'h01284820; mm[k][4] = 32'hac090004;
`endif
      rsp[k] = -100; ldat[k] = '0; lflt[k] = 1'b0; pd[k] = '0; pf[k] = 1'b0;
    end
  endtask
  task automatic rst_pulse();
    req_valid = 1'b0; load_en = 1'b0; rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 32'(vld[k]), 0);
      chk("rst_busy", k, 32'(bsy[k]), 0);
      chk("rst_data", k, dat[k], 0);
      chk("rst_fault", k, 32'(flt[k]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    c++;
  endtask
  task automatic step(input bit rv, input logic [31:0] a, input bit le, input logic [7:0] la, input logic [31:0] ld);
    bit     win, ready, busy, valid, f;
    longint av, off;
    int     idx;
    req_valid = rv; req_addr = a; load_en = le; load_addr = la; load_data = ld;
    #1;
    for (int k = 0; k < 3; k++) begin
      win   = c >= rsp[k] - WS[k] && c < rsp[k];
      ready = !win && !le;
      busy  = c >= rsp[k] - WS[k] && c <= rsp[k];
      valid = c == rsp[k];
      if (valid) begin ldat[k] = pd[k]; lflt[k] = pf[k]; end
      chk("ready", k, 32'(rdy[k]), 32'(ready));
      chk("busy", k, 32'(bsy[k]), 32'(busy));
      chk("valid", k, 32'(vld[k]), 32'(valid));
      chk("data", k, dat[k], ldat[k]);
      chk("fault", k, 32'(flt[k]), 32'(lflt[k]));
      if (rv && ready) begin
        av  = longint'(a);
        off = av - longint'(BA[k]);
        f   = (av % 4 != 0) || (av < longint'(BA[k])) || (off / 4 >= DP[k]);
        pf[k] = f;
        pd[k] = '0;
        if (!f) pd[k] = mm[k][int'(off / 4)];
        rsp[k] = c + WS[k] + 1;
      end
      idx = int'(la) & LM[k];
      if (le && idx < DP[k]) mm[k][idx] = ld;
    end
    c++;
    @(negedge clk);
  endtask
  task automatic fetch(input logic [31:0] a);
    step(1, a, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] corner [6];
    logic [31:0] a;
    corner = '{32'hFC, 32'h100, 32'h3FC, 32'h400, 32'h1BC, 32'h1C0};
    rst_pulse();
    for (int i = 0; i < 64; i++) step(0, 0, 1, 8'(i), $urandom);
    step(0, 0, 1, 8'd1, 32'h3409000a);
    step(0, 0, 1, 8'd5, 32'h000000AA);
    fetch(32'h4);
    fetch(32'h0);
    fetch(32'h2);
    fetch(32'h400);
    fetch(32'h3FC);
    fetch(32'hFC);
    fetch(32'h1BC);
    fetch(32'h1C0);
    step(1, 32'h0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0);
    step(1, 32'h8, 1, 8'd9, 32'h12345678);
    step(1, 32'h8, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(1, 32'h14, 0, 0, 0);
    step(0, 0, 1, 8'd5, 32'h00000055);
    repeat (4) step(0, 0, 0, 0, 0);
    fetch(32'h14);
    fetch(32'h114);
    step(1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_pulse();
    fetch(32'hC);
    fetch(32'h10C);
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 4)
        0: a = {22'b0, 8'($urandom_range(0, 120)), 2'b00};
        1: a = corner[$urandom % 6];
        2: a = $urandom;
        default: a = 32'($urandom_range(0, 511));
      endcase
      if ($urandom % 150 == 0) rst_pulse();
      else step(($urandom % 3) != 0, a, ($urandom % 4) == 0, 8'($urandom), $urandom);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
